// File: rtl/rscl_wb_sched_pkg.sv
// rscl_wb_sched_pkg: shared register/word types and the pending-load queue entry
package rscl_wb_sched_pkg;
  typedef logic [4:0] rnum_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic  wen;
    rnum_t rd;
  } lq_entry_t;
endpackage

// File: rtl/rscl_wb_sched_if.sv
// rscl_wb_sched_if: issue, exec-writeback, load-response and RF-write signals of the writeback scheduler
interface rscl_wb_sched_if import rscl_wb_sched_pkg::*; ();
  logic  issue_valid;
  rnum_t issue_rs1;
  rnum_t issue_rs2;
  rnum_t issue_rd;
  logic  issue_wen;
  logic  issue_is_load;
  logic  issue_stall;
  logic  ex_wb_valid;
  rnum_t ex_wb_rd;
  word_t ex_wb_data;
  logic  ex_wb_ready;
  logic  d_d_valid;
  logic  d_d_ready;
  logic  d_d_err;
  word_t d_d_data;
  logic  rf_we;
  rnum_t rf_waddr;
  word_t rf_wdata;
  logic  load_err;
  rnum_t load_err_rd;
  logic  lq_idle;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wen, issue_is_load,
    output ex_wb_valid, ex_wb_rd, ex_wb_data, d_d_valid, d_d_err, d_d_data,
    input  issue_stall, ex_wb_ready, d_d_ready, rf_we, rf_waddr, rf_wdata,
    input  load_err, load_err_rd, lq_idle
  );
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wen, issue_is_load,
    input  ex_wb_valid, ex_wb_rd, ex_wb_data, d_d_valid, d_d_err, d_d_data,
    output issue_stall, ex_wb_ready, d_d_ready, rf_we, rf_waddr, rf_wdata,
    output load_err, load_err_rd, lq_idle
  );
endinterface

// File: rtl/rscl_wb_sched_lq.sv
// rscl_wb_lq: in-order FIFO of pending loads; push is ignored when full, pop when empty
module rscl_wb_lq import rscl_wb_sched_pkg::*; #(
  parameter int LQ_DEPTH = 4,
  localparam int LQ_AW = $clog2(LQ_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  lq_entry_t      din,
  output lq_entry_t      head,
  output logic           full,
  output logic           empty,
  output logic [LQ_AW:0] count
);
  lq_entry_t mem_q [LQ_DEPTH];
  lq_entry_t mem_d [LQ_DEPTH];
  logic [LQ_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LQ_AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (LQ_AW+1)'(LQ_DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head = mem_q[rp_q];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (LQ_AW+1)'(do_push) - (LQ_AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rscl_wb_sched.sv
// rscl_wb_sched: RF write-port arbiter (loads first) and busy-bit scoreboard for in-flight loads
module rscl_wb_sched import rscl_wb_sched_pkg::*; #(
  parameter int LQ_DEPTH = 4,
  localparam int LQ_AW = $clog2(LQ_DEPTH)
) (
  input logic clk,
  input logic rst,
  rscl_wb_sched_if.slave b
);
  logic [31:0] busy_q, busy_d;
  logic load_err_q, load_err_d;
  rnum_t load_err_rd_q, load_err_rd_d;
  lq_entry_t head, din;
  logic lq_full, lq_empty, push, ld_acc, ld_wr;
  logic [LQ_AW:0] lq_count;
  // full is registered, so a load never pushes into a full queue even if a pop happens this cycle
  assign b.issue_stall = b.issue_valid & (busy_q[b.issue_rs1] | busy_q[b.issue_rs2] |
                         (b.issue_wen & busy_q[b.issue_rd]) | (b.issue_is_load & lq_full));
  assign push = b.issue_valid & !b.issue_stall & b.issue_is_load;
  assign din = '{wen: b.issue_wen, rd: b.issue_rd};
  assign ld_acc = b.d_d_valid & !lq_empty;
  assign ld_wr = ld_acc & !b.d_d_err & head.wen & (head.rd != '0);
  assign b.d_d_ready = !lq_empty;
  assign b.ex_wb_ready = !ld_wr;
  assign b.rf_we = ld_wr | (b.ex_wb_valid & (b.ex_wb_rd != '0));
  assign b.rf_waddr = ld_wr ? head.rd : b.ex_wb_rd;
  assign b.rf_wdata = ld_wr ? b.d_d_data : b.ex_wb_data;
  assign b.load_err = load_err_q;
  assign b.load_err_rd = load_err_rd_q;
  assign b.lq_idle = lq_count == '0;
  rscl_wb_lq #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk(clk), .rst(rst), .push(push), .pop(ld_acc), .din(din),
    .head(head), .full(lq_full), .empty(lq_empty), .count(lq_count)
  );
  // busy clears at the same edge the RF commits, so a stalled reader sees the new value next cycle
  always_comb begin
    busy_d = busy_q;
    if (ld_acc & head.wen) busy_d[head.rd] = 1'b0;
    if (push & b.issue_wen) busy_d[b.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    load_err_d = ld_acc & b.d_d_err;
    load_err_rd_d = load_err_d ? head.rd : load_err_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      load_err_q <= 1'b0;
      load_err_rd_q <= '0;
    end else begin
      busy_q <= busy_d;
      load_err_q <= load_err_d;
      load_err_rd_q <= load_err_rd_d;
    end
  end
endmodule
